// File: rtl/rom_select_sequencer.sv
// Word-cycle master for the bit-serial ROM chips: 56-bit-time counter, SYNC and
// address-window decodes, and snooping of the IS bus for immediate/delayed ROM selects.
module rom_select_sequencer #(
  parameter int         NUM_ROMS  = 4,
  parameter logic [6:0] ROMSEL_OP = 7'b0010000,
  parameter logic [6:0] DELSEL_OP = 7'b0110100
) (
  input  logic                cph2,
  input  logic                pon_n,
  input  logic                resync,
  input  logic                is_in,
  output logic [5:0]          bit_cnt,
  output logic                sync,
  output logic                ia_win,
  output logic [NUM_ROMS-1:0] rom_en,
  output logic [2:0]          rom_page,
  output logic                del_pend,
  output logic                bad_sel
);

  localparam logic [5:0] LAST_BIT   = 6'd55;
  localparam logic [3:0] NUM_ROMS_W = 4'(NUM_ROMS);

  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic       sync_q, sync_d;
  logic       ia_win_q, ia_win_d;
  logic [9:0] inst_q, inst_d;
  logic [2:0] rom_page_q, rom_page_d;
  logic [2:0] del_page_q, del_page_d;
  logic       del_pend_q, del_pend_d;
  logic       bad_sel_q, bad_sel_d;
  logic       word_end;

  // Decode only on a natural wrap; a resync abandons the word in flight.
  assign word_end = (bit_cnt_q == LAST_BIT) && !resync;

  always_comb begin
    bit_cnt_d = bit_cnt_q + 6'd1;
    if (resync || bit_cnt_q == LAST_BIT) begin
      bit_cnt_d = 6'd0;
    end
    // Decodes are taken from the next count so they line up with bit_cnt.
    sync_d   = (bit_cnt_d >= 6'd45) && (bit_cnt_d <= 6'd54);
    ia_win_d = (bit_cnt_d >= 6'd19) && (bit_cnt_d <= 6'd26);
  end

  always_comb begin
    inst_d = inst_q;
    if (sync_q) begin
      inst_d = {is_in, inst_q[9:1]};
    end
  end

  always_comb begin
    rom_page_d = rom_page_q;
    del_page_d = del_page_q;
    del_pend_d = del_pend_q;
    bad_sel_d  = bad_sel_q;
    if (word_end) begin
      if (inst_q[6:0] == ROMSEL_OP) begin
        rom_page_d = inst_q[9:7];
        del_pend_d = 1'b0;
      end else if (inst_q[6:0] == DELSEL_OP) begin
        del_page_d = inst_q[9:7];
        del_pend_d = 1'b1;
      end else if (del_pend_q && inst_q[0]) begin
        rom_page_d = del_page_q;
        del_pend_d = 1'b0;
      end
    end
    if ({1'b0, rom_page_d} >= NUM_ROMS_W) begin
      bad_sel_d = 1'b1;
    end
  end

  always_ff @(posedge cph2 or negedge pon_n) begin
    if (!pon_n) begin
      bit_cnt_q  <= 6'd0;
      sync_q     <= 1'b0;
      ia_win_q   <= 1'b0;
      inst_q     <= 10'd0;
      rom_page_q <= 3'd0;
      del_page_q <= 3'd0;
      del_pend_q <= 1'b0;
      bad_sel_q  <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      sync_q     <= sync_d;
      ia_win_q   <= ia_win_d;
      inst_q     <= inst_d;
      rom_page_q <= rom_page_d;
      del_page_q <= del_page_d;
      del_pend_q <= del_pend_d;
      bad_sel_q  <= bad_sel_d;
    end
  end

  // An out-of-range page matches no chip, leaving the IS bus idle.
  generate
    for (genvar gi = 0; gi < NUM_ROMS; gi++) begin : g_rom_en
      assign rom_en[gi] = (rom_page_q == 3'(gi));
    end
  endgenerate

  assign bit_cnt  = bit_cnt_q;
  assign sync     = sync_q;
  assign ia_win   = ia_win_q;
  assign rom_page = rom_page_q;
  assign del_pend = del_pend_q;
  assign bad_sel  = bad_sel_q;

endmodule

// File: tb/tb_rom_select_sequencer.sv
// Directed bench for rom_select_sequencer: word counter decodes, select decoding,
// out-of-range pages, resync and asynchronous reset.
module tb_rom_select_sequencer;

  logic       cph2;
  logic       pon_n;
  logic       resync;
  logic       is_in;
  logic [5:0] bit_cnt;
  logic       sync;
  logic       ia_win;
  logic [3:0] rom_en;
  logic [2:0] rom_page;
  logic       del_pend;
  logic       bad_sel;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] OP_SEL = 7'b0010000;
  localparam logic [6:0] OP_DEL = 7'b0110100;

  rom_select_sequencer #(
    .NUM_ROMS (4),
    .ROMSEL_OP(7'b0010000),
    .DELSEL_OP(7'b0110100)
  ) dut (
    .cph2    (cph2),
    .pon_n   (pon_n),
    .resync  (resync),
    .is_in   (is_in),
    .bit_cnt (bit_cnt),
    .sync    (sync),
    .ia_win  (ia_win),
    .rom_en  (rom_en),
    .rom_page(rom_page),
    .del_pend(del_pend),
    .bad_sel (bad_sel)
  );

  initial begin
    cph2 = 1'b0;
    forever #5 cph2 = ~cph2;
  end

  // Leaves the bench 1 time unit after a posedge with bit_cnt at 0.
  task automatic do_reset();
    pon_n  = 1'b0;
    resync = 1'b0;
    is_in  = 1'b0;
    @(posedge cph2);
    #1;
    pon_n = 1'b1;
  endtask

  // Plays one full 56-bit word starting at bit_cnt 0; ends at the next bit_cnt 0.
  task automatic send_word(input logic [9:0] w);
    for (int c = 0; c < 56; c++) begin
      is_in = (c >= 45 && c <= 54) ? w[c-45] : 1'b0;
      @(posedge cph2);
      #1;
    end
    is_in = 1'b0;
    $display("word 0x%03h -> bit_cnt=%0d rom_page=%0d rom_en=%b del_pend=%0d bad_sel=%0d",
             w, bit_cnt, rom_page, rom_en, del_pend, bad_sel);
  endtask

  task automatic test_reset();
    pon_n  = 1'b0;
    resync = 1'b0;
    is_in  = 1'b0;
    #1;
    checks++; if (bit_cnt !== 6'd0) begin errors++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL reset_sync got=%b exp=0", sync); end
    checks++; if (ia_win !== 1'b0) begin errors++; $display("FAIL reset_ia_win got=%b exp=0", ia_win); end
    checks++; if (rom_en !== 4'b0001) begin errors++; $display("FAIL reset_rom_en got=%b exp=0001", rom_en); end
    checks++; if (rom_page !== 3'd0) begin errors++; $display("FAIL reset_rom_page got=%0d exp=0", rom_page); end
    checks++; if (del_pend !== 1'b0) begin errors++; $display("FAIL reset_del_pend got=%b exp=0", del_pend); end
    checks++; if (bad_sel !== 1'b0) begin errors++; $display("FAIL reset_bad_sel got=%b exp=0", bad_sel); end
    @(posedge cph2);
    #1;
    checks++; if (bit_cnt !== 6'd0) begin errors++; $display("FAIL reset_held_bit_cnt got=%0d exp=0", bit_cnt); end
    pon_n = 1'b1;
    @(posedge cph2);
    #1;
    checks++; if (bit_cnt !== 6'd1) begin errors++; $display("FAIL reset_release_count got=%0d exp=1", bit_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_free_run();
    logic [5:0] exp_cnt;
    logic       exp_sync;
    logic       exp_ia;
    do_reset();
    for (int c = 0; c < 112; c++) begin
      exp_cnt  = 6'(c % 56);
      exp_sync = (exp_cnt >= 6'd45) && (exp_cnt <= 6'd54);
      exp_ia   = (exp_cnt >= 6'd19) && (exp_cnt <= 6'd26);
      checks++; if (bit_cnt !== exp_cnt) begin errors++; $display("FAIL run_bit_cnt cyc=%0d got=%0d exp=%0d", c, bit_cnt, exp_cnt); end
      checks++; if (sync !== exp_sync) begin errors++; $display("FAIL run_sync cyc=%0d got=%b exp=%b", c, sync, exp_sync); end
      checks++; if (ia_win !== exp_ia) begin errors++; $display("FAIL run_ia_win cyc=%0d got=%b exp=%b", c, ia_win, exp_ia); end
      @(posedge cph2);
      #1;
    end
    checks++; if (bit_cnt !== 6'd0) begin errors++; $display("FAIL run_end_bit_cnt got=%0d exp=0", bit_cnt); end
    checks++; if (rom_en !== 4'b0001) begin errors++; $display("FAIL run_rom_en got=%b exp=0001", rom_en); end
    $display("test_free_run done");
  endtask

  task automatic test_immediate();
    do_reset();
    send_word({3'd2, OP_SEL});
    checks++; if (bit_cnt !== 6'd0) begin errors++; $display("FAIL imm_bit_cnt got=%0d exp=0", bit_cnt); end
    checks++; if (rom_page !== 3'd2) begin errors++; $display("FAIL imm_rom_page got=%0d exp=2", rom_page); end
    checks++; if (rom_en !== 4'b0100) begin errors++; $display("FAIL imm_rom_en got=%b exp=0100", rom_en); end
    checks++; if (del_pend !== 1'b0) begin errors++; $display("FAIL imm_del_pend got=%b exp=0", del_pend); end
  endtask

  task automatic test_delayed();
    do_reset();
    send_word({3'd3, OP_DEL});
    checks++; if (del_pend !== 1'b1) begin errors++; $display("FAIL del_arm_pend got=%b exp=1", del_pend); end
    checks++; if (rom_page !== 3'd0) begin errors++; $display("FAIL del_arm_page got=%0d exp=0", rom_page); end
    send_word(10'h000);
    checks++; if (rom_page !== 3'd0) begin errors++; $display("FAIL del_nojump_page got=%0d exp=0", rom_page); end
    checks++; if (del_pend !== 1'b1) begin errors++; $display("FAIL del_nojump_pend got=%b exp=1", del_pend); end
    send_word(10'h003);
    checks++; if (rom_page !== 3'd3) begin errors++; $display("FAIL del_jump_page got=%0d exp=3", rom_page); end
    checks++; if (rom_en !== 4'b1000) begin errors++; $display("FAIL del_jump_rom_en got=%b exp=1000", rom_en); end
    checks++; if (del_pend !== 1'b0) begin errors++; $display("FAIL del_jump_pend got=%b exp=0", del_pend); end
  endtask

  task automatic test_cancel();
    do_reset();
    send_word({3'd1, OP_DEL});
    send_word({3'd2, OP_SEL});
    checks++; if (rom_page !== 3'd2) begin errors++; $display("FAIL cancel_page got=%0d exp=2", rom_page); end
    checks++; if (del_pend !== 1'b0) begin errors++; $display("FAIL cancel_pend got=%b exp=0", del_pend); end
    send_word(10'h003);
    checks++; if (rom_page !== 3'd2) begin errors++; $display("FAIL cancel_jump_page got=%0d exp=2", rom_page); end
    checks++; if (rom_en !== 4'b0100) begin errors++; $display("FAIL cancel_jump_rom_en got=%b exp=0100", rom_en); end
  endtask

  task automatic test_bad_sel();
    do_reset();
    send_word({3'd5, OP_SEL});
    checks++; if (rom_page !== 3'd5) begin errors++; $display("FAIL bad_page got=%0d exp=5", rom_page); end
    checks++; if (rom_en !== 4'b0000) begin errors++; $display("FAIL bad_rom_en got=%b exp=0000", rom_en); end
    checks++; if (bad_sel !== 1'b1) begin errors++; $display("FAIL bad_sel_set got=%b exp=1", bad_sel); end
    send_word({3'd1, OP_SEL});
    checks++; if (rom_en !== 4'b0010) begin errors++; $display("FAIL bad_recover_rom_en got=%b exp=0010", rom_en); end
    checks++; if (bad_sel !== 1'b1) begin errors++; $display("FAIL bad_sel_sticky got=%b exp=1", bad_sel); end
  endtask

  task automatic test_resync();
    logic [9:0] w;
    w = {3'd2, OP_SEL};
    do_reset();
    for (int c = 0; c < 56; c++) begin
      is_in  = (c >= 45 && c <= 54) ? w[c-45] : 1'b0;
      resync = (c == 50);
      @(posedge cph2);
      #1;
      if (c == 50) begin
        resync = 1'b0;
        break;
      end
    end
    is_in = 1'b0;
    checks++; if (bit_cnt !== 6'd0) begin errors++; $display("FAIL resync_bit_cnt got=%0d exp=0", bit_cnt); end
    checks++; if (rom_page !== 3'd0) begin errors++; $display("FAIL resync_page got=%0d exp=0", rom_page); end
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL resync_sync got=%b exp=0", sync); end
    send_word(10'h000);
    checks++; if (rom_page !== 3'd0) begin errors++; $display("FAIL resync_after_page got=%0d exp=0", rom_page); end
    checks++; if (rom_en !== 4'b0001) begin errors++; $display("FAIL resync_after_rom_en got=%b exp=0001", rom_en); end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_word({3'd6, OP_SEL});
    send_word({3'd3, OP_SEL});
    send_word({3'd1, OP_DEL});
    checks++; if (rom_page !== 3'd3 || del_pend !== 1'b1 || bad_sel !== 1'b1) begin
      errors++; $display("FAIL areset_setup got=page%0d/pend%b/bad%b exp=page3/pend1/bad1", rom_page, del_pend, bad_sel);
    end
    for (int c = 0; c < 30; c++) begin
      @(posedge cph2);
      #1;
    end
    checks++; if (bit_cnt !== 6'd30) begin errors++; $display("FAIL areset_pre_cnt got=%0d exp=30", bit_cnt); end
    #2;
    pon_n = 1'b0;
    #1;
    checks++; if (bit_cnt !== 6'd0) begin errors++; $display("FAIL areset_bit_cnt got=%0d exp=0", bit_cnt); end
    checks++; if (rom_page !== 3'd0) begin errors++; $display("FAIL areset_rom_page got=%0d exp=0", rom_page); end
    checks++; if (rom_en !== 4'b0001) begin errors++; $display("FAIL areset_rom_en got=%b exp=0001", rom_en); end
    checks++; if (del_pend !== 1'b0) begin errors++; $display("FAIL areset_del_pend got=%b exp=0", del_pend); end
    checks++; if (bad_sel !== 1'b0) begin errors++; $display("FAIL areset_bad_sel got=%b exp=0", bad_sel); end
    checks++; if (sync !== 1'b0 || ia_win !== 1'b0) begin errors++; $display("FAIL areset_decodes got=%b%b exp=00", sync, ia_win); end
    @(posedge cph2);
    #1;
    pon_n = 1'b1;
    @(posedge cph2);
    #1;
    checks++; if (bit_cnt !== 6'd1) begin errors++; $display("FAIL areset_restart got=%0d exp=1", bit_cnt); end
  endtask

  initial begin
    pon_n  = 1'b0;
    resync = 1'b0;
    is_in  = 1'b0;
    test_reset();
    test_free_run();
    test_immediate();
    test_delayed();
    test_cancel();
    test_bad_sel();
    test_resync();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
